// File: rtl/draw_scheduler.sv
// draw_scheduler: frame-level owner of the single VGA pixel-write port.
// Each frame: clear the screen to BG_COLOR, then start every enabled drawer
// in index order, forwarding the running drawer's pixel stream to the adapter.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   frame_tick          single-cycle frame redraw request
//   obj_enable          per-slot draw enable for this frame
//   obj_start           one-hot single-cycle start pulse to drawer idx
//   obj_plot/x/y/color  per-slot pixel streams, packed by slot
//   obj_done            per-slot done level
//   vga_plot/x/y/color  registered pixel write to the adapter
//   busy                high whenever the scheduler is not idle
//   frame_done          single-cycle pulse at end of frame
//   overrun             sticky: tick arrived with a request already pending
//   timeout_err         sticky: a drawer was aborted by the watchdog
module draw_scheduler #(
    parameter int unsigned        NUM_OBJ  = 6,
    parameter int unsigned        SCREEN_W = 320,
    parameter int unsigned        SCREEN_H = 240,
    parameter int unsigned        X_W      = 9,
    parameter int unsigned        Y_W      = 8,
    parameter int unsigned        COLOR_W  = 3,
    parameter logic [COLOR_W-1:0] BG_COLOR = '0,
    parameter int unsigned        TIMEOUT  = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame_tick,
    input  logic [NUM_OBJ-1:0]         obj_enable,
    output logic [NUM_OBJ-1:0]         obj_start,
    input  logic [NUM_OBJ-1:0]         obj_plot,
    input  logic [NUM_OBJ*X_W-1:0]     obj_x,
    input  logic [NUM_OBJ*Y_W-1:0]     obj_y,
    input  logic [NUM_OBJ*COLOR_W-1:0] obj_color,
    input  logic [NUM_OBJ-1:0]         obj_done,
    output logic                       vga_plot,
    output logic [X_W-1:0]             vga_x,
    output logic [Y_W-1:0]             vga_y,
    output logic [COLOR_W-1:0]         vga_color,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       overrun,
    output logic                       timeout_err
);

    localparam int unsigned IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
    localparam int unsigned WD_W  = (TIMEOUT > 4) ? $clog2(TIMEOUT) : 2;
    // Cycles at the start of WAIT_OBJ during which a stale done is ignored
    localparam int unsigned DONE_MASK = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_START_OBJ,
        S_WAIT_OBJ,
        S_NEXT_OBJ,
        S_FRAME_END
    } state_e;

    state_e               state_q, state_d;
    logic [X_W-1:0]       x_q, x_d;
    logic [Y_W-1:0]       y_q, y_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic                 pending_q, pending_d;

    logic [NUM_OBJ-1:0]   obj_start_q, obj_start_d;
    logic                 vga_plot_q, vga_plot_d;
    logic [X_W-1:0]       vga_x_q, vga_x_d;
    logic [Y_W-1:0]       vga_y_q, vga_y_d;
    logic [COLOR_W-1:0]   vga_color_q, vga_color_d;
    logic                 busy_q, busy_d;
    logic                 frame_done_q, frame_done_d;
    logic                 overrun_q, overrun_d;
    logic                 timeout_err_q, timeout_err_d;

    // Currently selected slot's drawer signals
    logic                 sel_plot;
    logic                 sel_done;
    logic [X_W-1:0]       sel_x;
    logic [Y_W-1:0]       sel_y;
    logic [COLOR_W-1:0]   sel_color;

    assign sel_plot  = obj_plot[idx_q];
    assign sel_done  = obj_done[idx_q];
    assign sel_x     = obj_x[idx_q*X_W +: X_W];
    assign sel_y     = obj_y[idx_q*Y_W +: Y_W];
    assign sel_color = obj_color[idx_q*COLOR_W +: COLOR_W];

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            idx_q         <= '0;
            wd_q          <= '0;
            pending_q     <= 1'b0;
            obj_start_q   <= '0;
            vga_plot_q    <= 1'b0;
            vga_x_q       <= '0;
            vga_y_q       <= '0;
            vga_color_q   <= '0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            idx_q         <= idx_d;
            wd_q          <= wd_d;
            pending_q     <= pending_d;
            obj_start_q   <= obj_start_d;
            vga_plot_q    <= vga_plot_d;
            vga_x_q       <= vga_x_d;
            vga_y_q       <= vga_y_d;
            vga_color_q   <= vga_color_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        idx_d         = idx_q;
        wd_d          = wd_q;
        pending_d     = pending_q;
        obj_start_d   = '0;
        vga_plot_d    = 1'b0;
        vga_x_d       = '0;
        vga_y_d       = '0;
        vga_color_d   = '0;
        frame_done_d  = 1'b0;
        overrun_d     = overrun_q;
        timeout_err_d = timeout_err_q;

        // A tick mid-frame is remembered; a second one collapses into it
        if (frame_tick && (state_q != S_IDLE) && (state_q != S_FRAME_END)) begin
            if (pending_q) begin
                overrun_d = 1'b1;
            end
            pending_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (frame_tick || pending_q) begin
                    state_d   = S_CLEAR;
                    x_d       = '0;
                    y_d       = '0;
                    pending_d = 1'b0;
                end
            end

            S_CLEAR: begin
                vga_plot_d  = 1'b1;
                vga_x_d     = x_q;
                vga_y_d     = y_q;
                vga_color_d = BG_COLOR;
                if (x_q == X_W'(SCREEN_W - 1)) begin
                    x_d = '0;
                    if (y_q == Y_W'(SCREEN_H - 1)) begin
                        y_d     = '0;
                        idx_d   = '0;
                        state_d = S_START_OBJ;
                    end else begin
                        y_d = y_q + 1'b1;
                    end
                end else begin
                    x_d = x_q + 1'b1;
                end
            end

            S_START_OBJ: begin
                if (obj_enable[idx_q]) begin
                    obj_start_d = NUM_OBJ'(1) << idx_q;
                    wd_d        = '0;
                    state_d     = S_WAIT_OBJ;
                end else begin
                    state_d = S_NEXT_OBJ;
                end
            end

            S_WAIT_OBJ: begin
                vga_plot_d  = sel_plot;
                vga_x_d     = sel_x;
                vga_y_d     = sel_y;
                vga_color_d = sel_color;
                if (sel_done && (wd_q >= WD_W'(DONE_MASK))) begin
                    state_d = S_NEXT_OBJ;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_NEXT_OBJ;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end

            S_NEXT_OBJ: begin
                if (idx_q == IDX_W'(NUM_OBJ - 1)) begin
                    state_d = S_FRAME_END;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_START_OBJ;
                end
            end

            S_FRAME_END: begin
                frame_done_d = 1'b1;
                // A tick here starts the next frame; it only overruns if one was queued
                if (pending_q || frame_tick) begin
                    state_d   = S_CLEAR;
                    x_d       = '0;
                    y_d       = '0;
                    pending_d = pending_q && frame_tick;
                    if (pending_q && frame_tick) begin
                        overrun_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign obj_start   = obj_start_q;
    assign vga_plot    = vga_plot_q;
    assign vga_x       = vga_x_q;
    assign vga_y       = vga_y_q;
    assign vga_color   = vga_color_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler with model drawers and a pixel scoreboard.
module tb_draw_scheduler;

    localparam int NO = 3;
    localparam int XW = 9;
    localparam int YW = 8;
    localparam int CW = 3;
    localparam int NPIX = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              frame_tick;
    logic [NO-1:0]     obj_enable;
    logic [NO-1:0]     obj_start;
    logic [NO-1:0]     obj_plot = '0;
    logic [NO*XW-1:0]  obj_x = '0;
    logic [NO*YW-1:0]  obj_y = '0;
    logic [NO*CW-1:0]  obj_color = '0;
    logic [NO-1:0]     obj_done = '0;
    logic              vga_plot;
    logic [XW-1:0]     vga_x;
    logic [YW-1:0]     vga_y;
    logic [CW-1:0]     vga_color;
    logic              busy;
    logic              frame_done;
    logic              overrun;
    logic              timeout_err;

    // Drawer model configuration (written by the stimulus only)
    logic [NO-1:0]     stale;
    logic [NO-1:0]     nodone;
    logic [NO-1:0]     skipdrv;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;
    int pix_cnt = 0;
    logic [XW+YW+CW-1:0] sb[$];
    logic [NO-1:0]       start_log[$];

    draw_scheduler #(
        .NUM_OBJ(NO), .SCREEN_W(4), .SCREEN_H(2), .X_W(XW), .Y_W(YW),
        .COLOR_W(CW), .BG_COLOR(3'b000), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .obj_enable(obj_enable),
        .obj_start(obj_start), .obj_plot(obj_plot), .obj_x(obj_x), .obj_y(obj_y),
        .obj_color(obj_color), .obj_done(obj_done), .vga_plot(vga_plot),
        .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color), .busy(busy),
        .frame_done(frame_done), .overrun(overrun), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Model drawers: NPIX pixels after start, done raised with the last pixel
    int   k[NO];
    logic act[NO];
    logic hold[NO];
    always @(negedge clk) begin
        for (int i = 0; i < NO; i++) begin
            if (!rst) begin
                act[i] = 1'b0;
                hold[i] = 1'b0;
                obj_plot[i] = 1'b0;
            end else if (obj_start[i]) begin
                act[i] = 1'b1;
                k[i] = 0;
                hold[i] = stale[i];
                if (!stale[i]) obj_done[i] = 1'b0;
                obj_plot[i] = 1'b0;
            end else if (act[i] && hold[i]) begin
                hold[i] = 1'b0;
                obj_plot[i] = 1'b0;
            end else if (act[i]) begin
                obj_plot[i] = 1'b1;
                obj_x[i*XW +: XW] = XW'(100 + 10*i + k[i]);
                obj_y[i*YW +: YW] = YW'(50 + 5*i + k[i]);
                obj_color[i*CW +: CW] = CW'(i + k[i] + 1);
                sb.push_back({XW'(100 + 10*i + k[i]), YW'(50 + 5*i + k[i]), CW'(i + k[i] + 1)});
                k[i]++;
                if (k[i] == NPIX) begin
                    act[i] = 1'b0;
                    obj_done[i] = !nodone[i];
                end else begin
                    obj_done[i] = 1'b0;
                end
            end else begin
                obj_plot[i] = skipdrv[i];
                if (skipdrv[i]) begin
                    obj_x[i*XW +: XW] = XW'(9'h1AB);
                    obj_y[i*YW +: YW] = YW'(8'hCD);
                    obj_color[i*CW +: CW] = CW'(3'd7);
                end
            end
        end
    end

    // Output monitor: scoreboard pops, start-pulse log, frame_done count
    always @(negedge clk) begin
        if (rst) begin
            if (obj_start != '0) begin
                start_log.push_back(obj_start);
                checks++;
                assert ($onehot(obj_start) === 1'b1) else begin
                    errors++;
                    $error("FAIL start_onehot: observed %b expected one-hot", obj_start);
                end
            end
            if (frame_done) fd_cnt++;
            if (vga_plot) begin
                pix_cnt++;
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_pixel: observed (%0d,%0d,%0d) expected none",
                           vga_x, vga_y, vga_color);
                end
                if (sb.size() != 0) begin
                    logic [XW+YW+CW-1:0] e;
                    e = sb.pop_front();
                    assert ({vga_x, vga_y, vga_color} === e) else begin
                        errors++;
                        $error("FAIL pixel: observed (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                               vga_x, vga_y, vga_color, e[19:11], e[10:3], e[2:0]);
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_plot"}, 32'(vga_plot), 0);
        chk({tag, "_xyc"}, 32'({vga_x, vga_y, vga_color}), 0);
        chk({tag, "_start"}, 32'(obj_start), 0);
        chk({tag, "_flags"}, 32'({busy, frame_done, overrun, timeout_err}), 0);
    endtask

    task automatic push_clear();
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 4; x++)
                sb.push_back({XW'(x), YW'(y), CW'(0)});
    endtask

    // Returns at the negedge after the edge that sampled the tick
    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle_bound"}, 32'(busy), 0);
        @(negedge clk);
    endtask

    task automatic wait_start(input int b, input string tag);
        int n = 0;
        while (!obj_start[b] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_start_bound"}, 32'(obj_start[b]), 1);
    endtask

    task automatic run_frame(input logic [NO-1:0] en, input int exp_pix, input string tag);
        int fd0 = fd_cnt;
        int p0 = pix_cnt;
        start_log.delete();
        obj_enable = en;
        push_clear();
        tick();
        wait_idle(tag);
        chk({tag, "_frame_done"}, 32'(fd_cnt - fd0), 1);
        chk({tag, "_pix"}, 32'(pix_cnt - p0), 32'(exp_pix));
        chk({tag, "_sb_empty"}, 32'(sb.size()), 0);
    endtask

    initial begin
        int fd0;
        int p0;
        int cnt;
        rst = 1'b0;
        frame_tick = 1'b0;
        obj_enable = '0;
        stale = '0;
        nodone = '0;
        skipdrv = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b1;

        // Clear-only frame with exact latency and plot run
        obj_enable = 3'b000;
        push_clear();
        fd0 = fd_cnt;
        tick();
        chk("clr_lat_plot0", 32'(vga_plot), 0);
        chk("clr_busy", 32'(busy), 1);
        @(negedge clk);
        chk("clr_first_pix", 32'({vga_plot, vga_x, vga_y}), 32'({1'b1, 9'd0, 8'd0}));
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cnt += 32'(vga_plot);
            @(negedge clk);
        end
        chk("clr_run_len", 32'(cnt), 8);
        chk("clr_plot_off", 32'(vga_plot), 0);
        wait_idle("clr");
        chk("clr_frame_done", 32'(fd_cnt - fd0), 1);
        chk("clr_sb_empty", 32'(sb.size()), 0);

        // Full frame, all slots
        run_frame(3'b111, 17, "full");
        chk("full_nstarts", 32'(start_log.size()), 3);
        chk("full_start0", 32'(start_log[0]), 1);
        chk("full_start1", 32'(start_log[1]), 2);
        chk("full_start2", 32'(start_log[2]), 4);

        // Skip slot 1 while its pixel inputs stay active
        skipdrv = 3'b010;
        run_frame(3'b101, 14, "skip");
        chk("skip_nstarts", 32'(start_log.size()), 2);
        chk("skip_start0", 32'(start_log[0]), 1);
        chk("skip_start1", 32'(start_log[1]), 4);
        skipdrv = '0;

        // Stale done on slot 0 held through the masked cycles
        chk("stale_pre_done", 32'(obj_done[0]), 1);
        stale = 3'b001;
        run_frame(3'b001, 11, "stale");
        stale = '0;

        // Watchdog on slot 1
        nodone = 3'b010;
        start_log.delete();
        obj_enable = 3'b111;
        push_clear();
        fd0 = fd_cnt;
        tick();
        wait_start(1, "tmo");
        repeat (15) @(negedge clk);
        chk("tmo_err_before", 32'(timeout_err), 0);
        @(negedge clk);
        chk("tmo_err_after", 32'(timeout_err), 1);
        wait_idle("tmo");
        chk("tmo_nstarts", 32'(start_log.size()), 3);
        chk("tmo_start2", 32'(start_log[2]), 4);
        chk("tmo_frame_done", 32'(fd_cnt - fd0), 1);
        chk("tmo_sb_empty", 32'(sb.size()), 0);
        nodone = '0;

        // Tick coincident with FRAME_END: back-to-back frames, no overrun
        obj_enable = 3'b000;
        push_clear();
        push_clear();
        fd0 = fd_cnt;
        p0 = pix_cnt;
        tick();
        repeat (14) @(negedge clk);
        chk("coin_busy_fe", 32'(busy), 1);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        chk("coin_fd_pulse", 32'({frame_done, busy}), 32'(2'b11));
        wait_idle("coin");
        chk("coin_frames", 32'(fd_cnt - fd0), 2);
        chk("coin_pix", 32'(pix_cnt - p0), 16);
        chk("coin_overrun", 32'(overrun), 0);
        chk("coin_sb_empty", 32'(sb.size()), 0);

        // Two extra ticks during CLEAR: overrun and exactly one more frame
        push_clear();
        push_clear();
        fd0 = fd_cnt;
        p0 = pix_cnt;
        tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        chk("ovr_flag", 32'(overrun), 1);
        wait_idle("ovr");
        chk("ovr_frames", 32'(fd_cnt - fd0), 2);
        chk("ovr_pix", 32'(pix_cnt - p0), 16);
        chk("ovr_sb_empty", 32'(sb.size()), 0);

        // Reset during WAIT_OBJ aborts everything at once
        obj_enable = 3'b111;
        push_clear();
        tick();
        wait_start(0, "rstw");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_zero("rstw");
        repeat (3) @(negedge clk);
        sb.delete();
        start_log.delete();
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("rstw_no_start", 32'(start_log.size()), 0);
        chk("rstw_idle", 32'({busy, vga_plot}), 0);

        // Recovery frame after reset
        run_frame(3'b111, 17, "recover");
        chk("recover_nstarts", 32'(start_log.size()), 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
